bcd_wide_add_seq: RTL and testbench

// - Sequencer that adds two CHUNKS*3-digit BCD operands using one shared 3-digit BCD adder.
// - Processes one 3-digit chunk per clock, least-significant chunk first, and ripples the carry between chunks in a register.
// - Sits between a valid/ready requester and the combinational 3-digit BCD adder, which is instantiated outside this block.
// - Rejects operands containing non-BCD digits (nibble > 9).

---
 rtl/bcd_wide_add_seq_if.sv | 28 ++
 rtl/bcd_wide_add_seq.sv | 110 +++++++++++
 tb/tb_bcd_wide_add_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_wide_add_seq_if.sv
// Requester-side handshake bundle for bcd_wide_add_seq: operand request channel
// and result channel, each with valid/ready.
interface bcd_wide_add_seq_if #(
  parameter int CHUNKS = 4
);
  localparam int W = 12 * CHUNKS;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  modport master (
    output start_valid, a, b, cin, res_ready,
    input  start_ready, res_valid, sum, cout, err
  );

  modport slave (
    input  start_valid, a, b, cin, res_ready,
    output start_ready, res_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_wide_add_seq.sv
// Wide BCD adder sequencer: feeds one 3-digit chunk per clock to an external
// combinational 3-digit BCD adder, LS chunk first, rippling the carry in a register.
module bcd_wide_add_seq #(
  parameter int CHUNKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_wide_add_seq_if.slave        bus,
  output logic                     busy,
  output logic [11:0]              add_a,
  output logic [11:0]              add_b,
  output logic                     add_cin,
  input  logic [11:0]              add_s,
  input  logic                     add_cout
);
  localparam int W  = 12 * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          err_r;
  logic          req_bad;
  logic          accept;
  logic          last_chunk;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 3 * CHUNKS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    bus.start_ready = 1'b0;
    bus.res_valid   = 1'b0;
    busy            = 1'b0;
    add_a           = 12'd0;
    add_b           = 12'd0;
    add_cin         = 1'b0;
    req_bad         = has_bad_digit(bus.a) | has_bad_digit(bus.b);
    accept          = 1'b0;
    last_chunk      = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        accept          = bus.start_valid;
        if (bus.start_valid) state_next = req_bad ? DONE : CALC;
      end
      CALC: begin
        busy    = 1'b1;
        add_a   = op_a[12*idx +: 12];
        add_b   = op_b[12*idx +: 12];
        add_cin = carry;
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results persist after handoff; only a new accept or reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (accept) begin
      op_a   <= bus.a;
      op_b   <= bus.b;
      carry  <= bus.cin;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      err_r  <= req_bad;
    end else if (state == CALC) begin
      sum_r[12*idx +: 12] <= add_s;
      carry               <= add_cout;
      if (last_chunk) cout_r <= add_cout;
      else            idx    <= idx + IW'(1);
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.err  = err_r;
endmodule

// File: tb/tb_bcd_wide_add_seq.sv
// Self-checking bench for bcd_wide_add_seq: vector table, randomized ops against a
// decimal-arithmetic model, plus backpressure and mid-CALC reset sequences.
module tb_bcd_wide_add_seq;
  localparam int CHUNKS = 4;
  localparam int W      = 12 * CHUNKS;
  localparam longint unsigned LIMIT = 64'd1_000_000_000_000;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [11:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  int          compared   = 0;
  int          mismatched = 0;

  bcd_wide_add_seq_if #(.CHUNKS(CHUNKS)) bus ();

  bcd_wide_add_seq #(.CHUNKS(CHUNKS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational 3-digit BCD adder.
  function automatic logic [12:0] bcd3_add(input logic [11:0] x, input logic [11:0] y, input logic c);
    logic [11:0] s;
    int          cy, d;
    cy = int'(c);
    s  = '0;
    for (int i = 0; i < 3; i++) begin
      d  = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cy;
      cy = (d > 9) ? 1 : 0;
      s[4*i +: 4] = 4'(d % 10);
    end
    return {cy[0], s};
  endfunction

  assign {add_cout, add_s} = bcd3_add(add_a, add_b, add_cin);

  function automatic logic any_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 3 * CHUNKS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic longint unsigned to_int(input logic [W-1:0] v);
    longint unsigned r;
    r = 0;
    for (int i = 3 * CHUNKS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint unsigned v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 3 * CHUNKS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    vec_t            v;
    longint unsigned total;
    v.a = a; v.b = b; v.cin = cin;
    v.exp_err = any_bad(a) | any_bad(b);
    if (v.exp_err) begin
      v.exp_sum  = '0;
      v.exp_cout = 1'b0;
      v.exp_lat  = 0;
    end else begin
      total      = to_int(a) + to_int(b) + longint'(cin);
      v.exp_cout = (total >= LIMIT);
      v.exp_sum  = to_bcd(total % LIMIT);
      v.exp_lat  = CHUNKS;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns the number of edges after the accept edge until res_valid is seen (-1 on timeout).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               output int lat, output logic busy_seen);
    int w;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.start_valid = 1'b1;
    w = 0;
    while (!bus.start_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    lat       = -1;
    busy_seen = 1'b0;
    if (!bus.start_ready) begin
      bus.start_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.start_valid = 1'b0;
    w         = 0;
    busy_seen = busy;
    while (!bus.res_valid && w < 50) begin
      @(negedge clk);
      w++;
      busy_seen = busy_seen | busy;
    end
    if (bus.res_valid) lat = w;
  endtask

  task automatic releaseResult();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int   lat;
    logic bsy;
    applyStimulus(v.a, v.b, v.cin, lat, bsy);
    checkOutput({tag, "_lat"},  64'(lat),           64'(v.exp_lat));
    checkOutput({tag, "_sum"},  64'(bus.sum),       64'(v.exp_sum));
    checkOutput({tag, "_cout"}, 64'(bus.cout),      64'(v.exp_cout));
    checkOutput({tag, "_err"},  64'(bus.err),       64'(v.exp_err));
    if (v.exp_err) checkOutput({tag, "_busy"}, 64'(bsy), 64'd0);
    releaseResult();
    checkOutput({tag, "_rv_drop"}, 64'(bus.res_valid), 64'd0);
    checkOutput({tag, "_held"},    64'(bus.sum),       64'(v.exp_sum));
  endtask

  initial begin
    vec_t         vecs[7];
    vec_t         rv;
    logic [W-1:0] ra, rb;
    int           lat, d;
    logic         bsy;

    vecs[0] = '{48'h000000000999, 48'h000000000001, 1'b0, 48'h000000001000, 1'b0, 1'b0, CHUNKS};
    vecs[1] = '{48'h999999999999, 48'h000000000000, 1'b1, 48'h000000000000, 1'b1, 1'b0, CHUNKS};
    vecs[2] = '{48'h00000000000A, 48'h000000000000, 1'b0, 48'h000000000000, 1'b0, 1'b1, 0};
    vecs[3] = '{48'h500000000000, 48'h500000000000, 1'b0, 48'h000000000000, 1'b1, 1'b0, CHUNKS};
    vecs[4] = '{48'h000000999999, 48'h000000000001, 1'b0, 48'h000001000000, 1'b0, 1'b0, CHUNKS};
    vecs[5] = '{48'h000000000000, 48'hF00000000000, 1'b1, 48'h000000000000, 1'b0, 1'b1, 0};
    vecs[6] = '{48'h123456789012, 48'h876543210987, 1'b1, 48'h000000000000, 1'b1, 1'b0, CHUNKS};

    rst = 1'b1;
    bus.start_valid = 1'b0; bus.res_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_start_ready", 64'(bus.start_ready), 64'd1);
    checkOutput("rst_res_valid",   64'(bus.res_valid),   64'd0);
    checkOutput("rst_sum",         64'(bus.sum),         64'd0);
    checkOutput("rst_cout",        64'(bus.cout),        64'd0);
    checkOutput("rst_err",         64'(bus.err),         64'd0);
    checkOutput("rst_busy",        64'(busy),            64'd0);
    checkOutput("rst_add_a",       64'(add_a),           64'd0);

    foreach (vecs[i]) runVector(vecs[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3 * CHUNKS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) begin
        d = int'($urandom_range(0, 3 * CHUNKS - 1));
        if ($urandom_range(0, 1) == 0) ra[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*d +: 4] = 4'($urandom_range(10, 15));
      end
      rv = model(ra, rb, 1'($urandom_range(0, 1)));
      runVector(rv, $sformatf("rnd%0d", n));
    end

    // Backpressure: result must hold and no new request may be taken.
    applyStimulus(48'h000000000123, 48'h000000000456, 1'b0, lat, bsy);
    checkOutput("bp_lat", 64'(lat), 64'(CHUNKS));
    bus.a = 48'h000000000999; bus.b = 48'h000000000999;
    for (int i = 0; i < 10; i++) begin
      bus.start_valid = i[0];
      @(negedge clk);
      checkOutput("bp_sum",         64'(bus.sum),         64'h579);
      checkOutput("bp_res_valid",   64'(bus.res_valid),   64'd1);
      checkOutput("bp_start_ready", 64'(bus.start_ready), 64'd0);
    end
    bus.start_valid = 1'b0;
    releaseResult();
    checkOutput("bp_rv_drop", 64'(bus.res_valid), 64'd0);
    checkOutput("bp_idle",    64'(bus.start_ready), 64'd1);
    checkOutput("bp_held",    64'(bus.sum),         64'h579);

    // Reset while the third chunk is being processed.
    @(negedge clk);
    bus.a = 48'h999999999999; bus.b = 48'h000000000001; bus.cin = 1'b0;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_start_ready", 64'(bus.start_ready), 64'd1);
    checkOutput("mid_busy_after",  64'(busy),            64'd0);
    checkOutput("mid_sum",         64'(bus.sum),         64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("mid_no_res_valid", 64'(bus.res_valid), 64'd0);
    end
    rv = model(48'h000000000005, 48'h000000000007, 1'b0);
    checkOutput("mid_model_sum", 64'(rv.exp_sum), 64'h12);
    runVector(rv, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
